ws2812b_rx: RTL

Single-wire WS2812B-protocol receiver: the decode end of the LED-strip link driven by our WS2812B transmitter. It samples the NRZ line, classifies each high pulse as a '0' or '1' by width, and assembles MSB-first 24-bit words. It presents the words on a valid/ready handshake and flags the reset (latch) gap. It is used as a loopback monitor on the strip output and as a front end for daisy-chain test fixtures.

---
 rtl/ws2812b_rx_if.sv | 32 +++
 rtl/ws2812b_rx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ws2812b_rx_if.sv
// ws2812b_rx_if: serial line plus received-word handshake for the WS2812B receiver.
// The master modport is the receiver side (drives the word, valid and status flags);
// the slave modport is the line driver / word consumer side.
interface ws2812b_rx_if;
  logic        din;
  logic [23:0] data_out;
  logic        valid;
  logic        ready;
  logic        latch;
  logic        overrun;
  logic        err;

  modport master (
    input  din,
    input  ready,
    output data_out,
    output valid,
    output latch,
    output overrun,
    output err
  );

  modport slave (
    output din,
    output ready,
    input  data_out,
    input  valid,
    input  latch,
    input  overrun,
    input  err
  );
endinterface

// File: rtl/ws2812b_rx.sv
// ws2812b_rx: WS2812B single-wire receiver.
// Synchronizes the NRZ line, measures each high pulse against a width threshold,
// assembles MSB-first 24-bit words, presents them on a valid/ready handshake and
// pulses latch on a reset gap. Optional pulse-width checking is compiled in with
// the macro WS2812B_RX_ERR_EN; without it err is constant 0.
module ws2812b_rx #(
  parameter int CLOCK_MHZ = 64,
  parameter int THRESH_NS = 600,
  parameter int RESET_NS  = 50_000
) (
  input  logic         clk,
  input  logic         rst,
  ws2812b_rx_if.master bus
);

  // Cycle constants, rounded to the nearest clock.
  localparam logic [15:0] C_THRESH = 16'((THRESH_NS * CLOCK_MHZ + 500) / 1000);
  localparam logic [15:0] C_RESET  = 16'((RESET_NS  * CLOCK_MHZ + 500) / 1000);
  localparam logic [15:0] C_SAT    = 16'hFFFF;
`ifdef WS2812B_RX_ERR_EN
  localparam logic [15:0] C_MIN    = 16'((150  * CLOCK_MHZ + 500) / 1000);
  localparam logic [15:0] C_MAXH   = 16'((2000 * CLOCK_MHZ + 500) / 1000);
`endif

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_meta;
  logic        r_sync;
  logic        r_line;
  logic [15:0] r_cnt;
  logic [4:0]  r_bitcnt;
  logic [23:0] r_shift;
  logic [23:0] r_data;
  logic        r_valid;
  logic        r_latch;
  logic        r_overrun;
`ifdef WS2812B_RX_ERR_EN
  logic        r_err;
`endif

  logic [15:0] w_cnt_inc;
  logic        w_bit;
  logic [23:0] w_word;
  logic        w_take;
  logic        w_last_bit;
  logic        w_short;
  logic        w_long;

  // Saturating counter step, bit decision and handshake/pulse-check qualifiers.
  always_comb begin
    w_cnt_inc  = (r_cnt == C_SAT) ? r_cnt : (r_cnt + 16'd1);
    w_bit      = (r_cnt >= C_THRESH);
    w_word     = {r_shift[22:0], w_bit};
    w_take     = r_valid & bus.ready;
    w_last_bit = (r_bitcnt == 5'd23);
`ifdef WS2812B_RX_ERR_EN
    w_short    = (r_cnt < C_MIN);
    w_long     = (r_cnt >= C_MAXH);
`else
    w_short    = 1'b0;
    w_long     = 1'b0;
`endif
  end

  // Two-flop synchronizer on din, followed by the sample stage the FSM edge-detects on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_line <= 1'b0;
    end else begin
      r_meta <= bus.din;
      r_sync <= r_meta;
      r_line <= r_sync;
    end
  end

  // Line FSM: measures pulses, assembles words and drives the registered outputs.
  // Counters count samples, so an N-cycle pulse leaves r_cnt == N at its end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_SYNC;
      r_cnt     <= 16'd0;
      r_bitcnt  <= 5'd0;
      r_shift   <= 24'd0;
      r_data    <= 24'd0;
      r_valid   <= 1'b0;
      r_latch   <= 1'b0;
      r_overrun <= 1'b0;
`ifdef WS2812B_RX_ERR_EN
      r_err     <= 1'b0;
`endif
    end else begin
      r_latch <= 1'b0;
`ifdef WS2812B_RX_ERR_EN
      r_err   <= 1'b0;
`endif
      // A consume clears valid unless a word completes below in the same cycle.
      if (w_take) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        // Wait for the first full reset gap; anything high restarts the wait.
        ST_SYNC: begin
          if (r_line) begin
            r_cnt <= 16'd0;
          end else begin
            if (r_cnt == C_RESET) begin
              r_state <= ST_LOW;
            end
            r_cnt <= w_cnt_inc;
          end
        end

        // Low time between pulses; a long enough low is a latch gap.
        ST_LOW: begin
          if (r_line) begin
            r_state <= ST_HIGH;
            r_cnt   <= 16'd1;
          end else begin
            if (r_cnt == C_RESET) begin
              r_latch  <= 1'b1;
              r_bitcnt <= 5'd0;
            end
            r_cnt <= w_cnt_inc;
          end
        end

        // High pulse: measure width, decode on the falling edge.
        ST_HIGH: begin
          if (r_line) begin
            if (w_long) begin
`ifdef WS2812B_RX_ERR_EN
              r_err <= 1'b1;
`endif
              r_bitcnt <= 5'd0;
              r_state  <= ST_SYNC;
              r_cnt    <= 16'd0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end else if (w_short) begin
`ifdef WS2812B_RX_ERR_EN
            r_err <= 1'b1;
`endif
            r_bitcnt <= 5'd0;
            r_state  <= ST_SYNC;
            r_cnt    <= 16'd1;
          end else begin
            r_shift <= w_word;
            r_state <= ST_LOW;
            r_cnt   <= 16'd1;
            if (w_last_bit) begin
              r_bitcnt <= 5'd0;
              if (r_valid && !bus.ready) begin
                r_overrun <= 1'b1;
              end else begin
                r_data  <= w_word;
                r_valid <= 1'b1;
              end
            end else begin
              r_bitcnt <= r_bitcnt + 5'd1;
            end
          end
        end

        default: begin
          r_state  <= ST_SYNC;
          r_cnt    <= 16'd0;
          r_bitcnt <= 5'd0;
        end
      endcase
    end
  end

  assign bus.data_out = r_data;
  assign bus.valid    = r_valid;
  assign bus.latch    = r_latch;
  assign bus.overrun  = r_overrun;
`ifdef WS2812B_RX_ERR_EN
  assign bus.err      = r_err;
`else
  assign bus.err      = 1'b0;
`endif

endmodule
